// File: rtl/serial_negate_ctrl_if.sv
// ---------------------------------------------------------------------------
// serial_negate_ctrl_if
//   Word-level handshake bundle for serial_negate_ctrl.
//   Input side : in_valid / in_data / in_ready   (producer offers a word)
//   Output side: out_valid / out_data / out_ready (consumer takes the result)
//   Modports:
//     master - the environment: drives in_valid, in_data, out_ready
//     slave  - the controller : drives in_ready, out_valid, out_data
// ---------------------------------------------------------------------------
interface serial_negate_ctrl_if #(
  parameter int WIDTH = 8
);
  logic             in_valid;
  logic [WIDTH-1:0] in_data;
  logic             in_ready;
  logic             out_valid;
  logic [WIDTH-1:0] out_data;
  logic             out_ready;

  modport master (
    output in_valid, in_data, out_ready,
    input  in_ready, out_valid, out_data
  );

  modport slave (
    input  in_valid, in_data, out_ready,
    output in_ready, out_valid, out_data
  );
endinterface

// File: rtl/serial_negate_ctrl.sv
// ---------------------------------------------------------------------------
// serial_negate_ctrl
//   Two's-complement negation of a WIDTH-bit word, done bit-serially through
//   an external copy-until-first-1-then-invert converter. A word is captured
//   in IDLE, the converter is cleared for one cycle (CLEAR), the word is
//   streamed LSB first for WIDTH cycles (SHIFT) while the converter's answer
//   is shifted back in, and the result is offered until taken (DONE).
//
// Ports
//   clk, rst_n   : clock, synchronous active-low reset
//   bus          : serial_negate_ctrl_if.slave (in/out word handshakes)
//   conv_x       : serial bit to the converter, LSB first
//   conv_z       : converter's same-cycle response to conv_x
//   conv_rst_n   : converter clear, active-low, sampled on clk
//   ovf          : only with SERIAL_NEGATE_OVF_EN defined; high alongside
//                  out_valid when the word was the most-negative value
//                  (1 followed by WIDTH-1 zeros), whose negation overflows
//
// Parameters
//   WIDTH        : word width, 2..32
// ---------------------------------------------------------------------------
module serial_negate_ctrl #(
  parameter int WIDTH = 8
) (
  input  logic                 clk,
  input  logic                 rst_n,
  serial_negate_ctrl_if.slave  bus,
  output logic                 conv_x,
  input  logic                 conv_z,
  output logic                 conv_rst_n
`ifdef SERIAL_NEGATE_OVF_EN
  ,
  output logic                 ovf
`endif
);

  localparam int                CNT_W    = $clog2(WIDTH);
  localparam logic [CNT_W-1:0]  LAST_BIT = CNT_W'(WIDTH - 1);

  typedef enum logic [1:0] {
    IDLE,
    CLEAR,
    SHIFT,
    DONE
  } state_e;

  state_e             state_q, state_d;
  logic [WIDTH-1:0]   shreg_q, shreg_d;
  logic [WIDTH-1:0]   result_q, result_d;
  logic [CNT_W-1:0]   bit_cnt_q, bit_cnt_d;

  // NOTE: reset is synchronous, so it lives inside the clocked branch and the
  // sensitivity list carries only the clock edge.
  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge value of every other flop.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      shreg_q   <= '0;
      result_q  <= '0;
      bit_cnt_q <= '0;
    end else begin
      state_q   <= state_d;
      shreg_q   <= shreg_d;
      result_q  <= result_d;
      bit_cnt_q <= bit_cnt_d;
    end
  end

  // The shift register doubles as the result accumulator: as the operand
  // drains out of bit 0, converter answers fill in from the MSB, so after
  // WIDTH shifts it holds the negated word. result_q is loaded only on entry
  // to DONE, keeping out_data stable until the next word completes.
  always_comb begin
    // NOTE: every output of this block gets a default first; a path that
    // skipped an assignment would infer a latch.
    state_d   = state_q;
    shreg_d   = shreg_q;
    result_d  = result_q;
    bit_cnt_d = bit_cnt_q;

    unique case (state_q)
      IDLE: begin
        if (bus.in_valid) begin
          shreg_d   = bus.in_data;
          bit_cnt_d = '0;
          state_d   = CLEAR;
        end
      end
      CLEAR: begin
        state_d = SHIFT;
      end
      SHIFT: begin
        shreg_d = {conv_z, shreg_q[WIDTH-1:1]};
        if (bit_cnt_q == LAST_BIT) begin
          result_d = {conv_z, shreg_q[WIDTH-1:1]};
          state_d  = DONE;
        end else begin
          bit_cnt_d = bit_cnt_q + CNT_W'(1);
        end
      end
      DONE: begin
        if (bus.out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Outputs are decoded from state; gating with rst_n keeps the handshakes
  // and the converter quiet during the reset cycle itself, which also
  // suppresses out_valid for a word aborted in DONE.
  assign bus.in_ready  = rst_n && (state_q == IDLE);
  assign bus.out_valid = rst_n && (state_q == DONE);
  assign bus.out_data  = result_q;
  assign conv_rst_n    = rst_n && (state_q == SHIFT);
  assign conv_x        = conv_rst_n && shreg_q[0];

`ifdef SERIAL_NEGATE_OVF_EN
  localparam logic [WIDTH-1:0] MOST_NEG = {1'b1, {(WIDTH-1){1'b0}}};

  logic ovf_q, ovf_d;

  always_ff @(posedge clk) begin
    if (!rst_n) ovf_q <= 1'b0;
    else        ovf_q <= ovf_d;
  end

  // Flag is decided at capture time from the raw operand.
  always_comb begin
    ovf_d = ovf_q;
    if (state_q == IDLE && bus.in_valid) ovf_d = (bus.in_data == MOST_NEG);
  end

  assign ovf = bus.out_valid && ovf_q;
`endif

endmodule

// File: tb/tb_serial_negate_ctrl.sv
// ---------------------------------------------------------------------------
// tb_serial_negate_ctrl
//   Scoreboard bench for serial_negate_ctrl (WIDTH=8). Accepted words push
//   their expected negation, overflow flag and acceptance edge into a queue;
//   an independent monitor pops and compares whenever a new result appears.
//   The converter is modelled here as copy-until-first-1-then-invert.
// ---------------------------------------------------------------------------
module tb_serial_negate_ctrl;

  localparam int W = 8;

  logic clk;
  logic rst_n;
  logic conv_x;
  logic conv_z;
  logic conv_rst_n;
`ifdef SERIAL_NEGATE_OVF_EN
  logic ovf;
`endif

  serial_negate_ctrl_if #(.WIDTH(W)) bus ();

  serial_negate_ctrl #(.WIDTH(W)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .bus        (bus),
    .conv_x     (conv_x),
    .conv_z     (conv_z),
    .conv_rst_n (conv_rst_n)
`ifdef SERIAL_NEGATE_OVF_EN
    ,
    .ovf        (ovf)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- converter model ----------------
  logic conv_seen;
  always @(posedge clk) begin
    if (!conv_rst_n)  conv_seen <= 1'b0;
    else if (conv_x)  conv_seen <= 1'b1;
  end
  assign conv_z = conv_seen ? ~conv_x : conv_x;

  // ---------------- bookkeeping ----------------
  int total = 0;
  int bad   = 0;
  int edges = 0;

  always @(posedge clk) edges <= edges + 1;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (edge %0d)", name, act, exp, edges);
    end
  endtask

  typedef struct {
    logic [W-1:0] data;
    bit           ovf;
    int           acc_edge;
  } exp_t;

  exp_t sb_q[$];
  int   acc_log[$];

  // Reference: negation is (2^W - x) mod 2^W; overflow iff x == 2^(W-1).
  always @(negedge clk) begin
    exp_t e;
    if (rst_n && bus.in_valid && bus.in_ready) begin
      e.data     = W'((longint'(1) << W) - longint'(bus.in_data));
      e.ovf      = (longint'(bus.in_data) == (longint'(1) << (W - 1)));
      e.acc_edge = edges + 1;
      sb_q.push_back(e);
      acc_log.push_back(edges + 1);
    end
  end

  // ---------------- monitor ----------------
  logic [W-1:0] held;
  bit           prev_valid;
  bit           prev_ready;

  always @(negedge clk) begin
    exp_t e;
    if (!rst_n) begin
      held       = '0;
      prev_valid = 1'b0;
      prev_ready = 1'b0;
    end else begin
      if (bus.out_valid && !prev_valid) begin
        if (sb_q.size() == 0) begin
          check("unexpected_out_valid", 1, 0);
        end else begin
          e = sb_q.pop_front();
          check("out_data", bus.out_data, e.data);
          check("latency", edges - e.acc_edge, W + 1);
`ifdef SERIAL_NEGATE_OVF_EN
          check("ovf", ovf, e.ovf);
`endif
          held = e.data;
        end
      end else begin
        check("out_data_retained", bus.out_data, held);
      end
`ifdef SERIAL_NEGATE_OVF_EN
      if (!bus.out_valid) check("ovf_low", ovf, 0);
`endif
      if (!bus.out_valid && prev_valid && prev_ready)
        check("in_ready_after_done", bus.in_ready, 1);
      if (bus.in_ready || bus.out_valid) begin
        check("conv_rst_n_idle", conv_rst_n, 0);
        check("conv_x_idle", conv_x, 0);
      end
      if (bus.in_ready && bus.out_valid) check("ready_valid_overlap", 1, 0);
      prev_valid = bus.out_valid;
      prev_ready = bus.out_ready;
    end
  end

  // ---------------- consumer ----------------
  bit rand_ready  = 1'b0;
  bit ready_force = 1'b1;

  always @(posedge clk) begin
    #1;
    bus.out_ready = rand_ready ? 1'($urandom_range(0, 1)) : ready_force;
  end

  // ---------------- driver helpers ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Offer a word until accepted; returns just after the accepting edge.
  task automatic send(input logic [W-1:0] d, input bit keep_valid);
    bit got;
    got = 1'b0;
    bus.in_valid = 1'b1;
    bus.in_data  = d;
    for (int n = 0; n < 400 && !got; n++) begin
      @(negedge clk);
      if (bus.in_ready) got = 1'b1;
      tick();
    end
    check("accept_timeout", got, 1);
    if (!keep_valid) bus.in_valid = 1'b0;
  endtask

  task automatic drain();
    for (int n = 0; n < 3000 && sb_q.size() != 0; n++) @(negedge clk);
    check("drain", sb_q.size(), 0);
    tick();
    tick();
  endtask

  initial begin
    #500000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1);
  end

  // ---------------- stimulus ----------------
  initial begin
    logic [W-1:0] words[6];
    int           base;
    bit           seen_valid;

    words[0] = 8'h05; words[1] = 8'h00; words[2] = 8'hFF;
    words[3] = 8'h80; words[4] = 8'h7F; words[5] = 8'h01;

    rst_n        = 1'b0;
    bus.in_valid = 1'b0;
    bus.in_data  = '0;
    bus.out_ready = 1'b1;

    // Reset state
    tick();
    tick();
    @(negedge clk);
    check("rst_in_ready", bus.in_ready, 0);
    check("rst_out_valid", bus.out_valid, 0);
    check("rst_out_data", bus.out_data, 0);
    check("rst_conv_rst_n", conv_rst_n, 0);
    check("rst_conv_x", conv_x, 0);
    tick();
    rst_n = 1'b1;
    @(negedge clk);
    check("in_ready_after_release", bus.in_ready, 1);
    tick();

    // Directed words, consumer always ready
    foreach (words[i]) begin
      send(words[i], 1'b0);
      drain();
    end

    // Randomized words with random back-pressure and gaps
    rand_ready = 1'b1;
    for (int i = 0; i < 30; i++) begin
      int gap;
      gap = $urandom_range(0, 3);
      send(W'($urandom), 1'b0);
      repeat (gap) tick();
    end
    rand_ready  = 1'b0;
    ready_force = 1'b1;
    drain();

    // Back-pressure hold in DONE for 20 cycles
    ready_force = 1'b0;
    tick();
    send(8'h5A, 1'b0);
    seen_valid = 1'b0;
    for (int n = 0; n < 50 && !seen_valid; n++) begin
      @(negedge clk);
      if (bus.out_valid) seen_valid = 1'b1;
    end
    check("hold_reach_done", seen_valid, 1);
    for (int n = 0; n < 20; n++) begin
      check("hold_out_valid", bus.out_valid, 1);
      check("hold_out_data", bus.out_data, 8'hA6);
      check("hold_in_ready", bus.in_ready, 0);
      @(negedge clk);
    end
    ready_force = 1'b1;
    drain();

    // Reset during the third SHIFT cycle aborts the word
    send(8'h40, 1'b0);
    tick();
    tick();
    tick();
    rst_n = 1'b0;
    @(negedge clk);
    check("abort_in_ready_low", bus.in_ready, 0);
    check("abort_conv_rst_n", conv_rst_n, 0);
    tick();
    rst_n = 1'b1;
    void'(sb_q.pop_back());
    @(negedge clk);
    check("abort_idle", bus.in_ready, 1);
    check("abort_out_valid", bus.out_valid, 0);
    check("abort_out_data", bus.out_data, 0);
    tick();
    send(8'h03, 1'b0);
    drain();

    // Back-to-back words with in_valid held high
    base = acc_log.size();
    send(8'h11, 1'b1);
    send(8'h22, 1'b1);
    send(8'h33, 1'b0);
    drain();
    check("b2b_count", acc_log.size() - base, 3);
    if (acc_log.size() - base == 3) begin
      check("b2b_gap1", acc_log[base + 1] - acc_log[base], W + 3);
      check("b2b_gap2", acc_log[base + 2] - acc_log[base + 1], W + 3);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/serial_negate_ctrl.md
SERIAL_NEGATE_CTRL -- requirements
Module: serial_negate_ctrl

Interface
REQ-001 Parameter: WIDTH, 8, word width in bits; legal range 2..32.
REQ-002 Port: clk  input  1  rising-edge clock for all state.
REQ-003 Port: rst_n  input  1  reset, synchronous, active-low.
REQ-004 Port: in_valid  input  1  parallel word offered.
REQ-005 Port: in_data  input  WIDTH  word to negate (two's complement).
REQ-006 Port: in_ready  output  1  controller can accept a word.
REQ-007 Port: out_valid  output  1  negated result available.
REQ-008 Port: out_data  output  WIDTH  negated result.
REQ-009 Port: out_ready  input  1  consumer takes result.
REQ-010 Port: conv_x  output  1  serial bit to copy/invert converter, LSB first.
REQ-011 Port: conv_z  input  1  converter output, same-cycle (Mealy) response to conv_x.
REQ-012 Port: conv_rst_n  output  1  converter clear, active-low, sampled by converter on clk.

Function
REQ-013 States SHALL be IDLE, CLEAR, SHIFT, DONE; encoding free.
REQ-014 IDLE: in_ready=1; in_valid&in_ready -> capture in_data into shift register, bit_cnt=0, go CLEAR.
REQ-015 CLEAR: one cycle, conv_rst_n=0, conv_x=0, then go SHIFT.
REQ-016 SHIFT: conv_rst_n=1, conv_x=shreg[0]; each cycle shreg shifts right, conv_z shifts into result MSB, bit_cnt increments.
REQ-017 SHIFT lasts exactly WIDTH cycles; on bit_cnt==WIDTH-1 go DONE.
REQ-018 DONE: out_valid=1, out_data=result stable; out_ready -> IDLE; otherwise hold indefinitely.
REQ-019 conv_rst_n SHALL be 0 in every state except SHIFT; conv_x SHALL be 0 outside SHIFT.
REQ-020 in_ready SHALL be 0 in CLEAR, SHIFT, DONE; in_data changes there ignored.
REQ-021 Latency: word accepted at edge T -> out_valid high from cycle T+2+WIDTH.
REQ-022 Throughput: back-to-back words separated by minimum WIDTH+3 cycles (IDLE, CLEAR, WIDTH SHIFT, DONE).
REQ-023 out_data SHALL equal (~in_data+1) mod 2^WIDTH for any converter implementing copy-until-first-1-then-invert.
REQ-024 bit_cnt width SHALL be clog2(WIDTH), no wrap beyond WIDTH-1.
REQ-025 out_data SHALL retain last result after DONE->IDLE until next DONE.

Reset
REQ-026 rst_n=0 at an edge -> state IDLE, out_valid=0, out_data=0, shreg=0, bit_cnt=0, conv_x=0, conv_rst_n=0.
REQ-027 Reset mid-SHIFT or mid-DONE SHALL abort the word; no out_valid pulse for it.
REQ-028 in_ready SHALL be 0 while rst_n=0, 1 in first cycle after release.

Configuration
REQ-029 Macro SERIAL_NEGATE_OVF_EN: when defined, output port ovf (1 bit) present; ovf=1 with out_valid when captured word is 1 followed by WIDTH-1 zeros, else 0; reset 0.
REQ-030 Without SERIAL_NEGATE_OVF_EN: no ovf port, no overflow logic; all other behaviour identical.

Verification
REQ-031 WIDTH=8, in_data=0x05, out_ready=1 -> out_data=0xFB at cycle T+10, in_ready returns 1 next cycle.
REQ-032 in_data=0x00 -> out_data=0x00; in_data=0xFF -> out_data=0x01.
REQ-033 OVF_EN defined, in_data=0x80 -> out_data=0x80, ovf=1; in_data=0x7F -> 0x81, ovf=0.
REQ-034 out_ready=0 for 20 cycles in DONE -> out_valid and out_data held, in_ready=0 throughout.
REQ-035 rst_n=0 for one cycle at third SHIFT cycle -> IDLE next cycle, out_valid never asserted, next word 0x03 -> 0xFD.
REQ-036 in_valid held high with 3 words -> each accepted every 11 cycles, results correct in order.
